adder_subtractor: RTL and testbench
===================================

ADDER_SUBTRACTOR -- requirements
Module: adder_subtractor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter WIDTH SHALL default to 32 and set the operand and result width.
REQ-003 Port clk SHALL be an input, 1 bit wide, and be the rising-edge clock.
REQ-004 Port reset SHALL be an input, 1 bit wide, asynchronous and active-high.
REQ-005 Port in_valid SHALL be an input, 1 bit wide, and qualify the operands and op for the current cycle.
REQ-006 Port op SHALL be an input, 1 bit wide: 0 = add (A+B), 1 = subtract (A-B).
REQ-007 Port A SHALL be an input, WIDTH bits wide, and be the first operand.
REQ-008 Port B SHALL be an input, WIDTH bits wide, and be the second operand (the subtrahend when op=1).
REQ-009 Port out_valid SHALL be an output, 1 bit wide, asserted for one cycle per accepted operation.
REQ-010 Port Result SHALL be an output, WIDTH bits wide, holding the registered sum or difference.
REQ-011 Port carry_out SHALL be an output, 1 bit wide: carry out of the MSB (for op=1, 1 = no borrow).
REQ-012 Port overflow SHALL be an output, 1 bit wide, flagging signed two's-complement overflow.
REQ-013 Port zero SHALL be an output, 1 bit wide, asserted when Result == 0.
REQ-014 Port negative SHALL be an output, 1 bit wide, equal to Result[WIDTH-1].

Function
REQ-015 Addition SHALL compute A + B + 0 modulo 2^WIDTH.
REQ-016 Subtraction SHALL compute A + ~B + 1 modulo 2^WIDTH through the same carry chain, with no separate subtract path.
REQ-017 Latency SHALL be exactly 1 cycle: if in_valid is high at edge N, then Result, flags and out_valid=1 appear after edge N.
REQ-018 When in_valid=0 at an edge, out_valid SHALL go to 0 and Result and the flags SHALL hold their previous values.
REQ-019 The block SHALL accept back-to-back operations every cycle, with no stall and no backpressure.
REQ-020 overflow SHALL be carry into the MSB XOR carry out of the MSB.
REQ-021 Wrap-around SHALL be silent: 0xFFFFFFFF + 1 gives Result=0, carry_out=1, overflow=0.
REQ-022 The inputs SHALL be sampled only at the rising clock edge, and X on the inputs while in_valid=0 SHALL NOT propagate.

Reset
REQ-023 While reset=1, regardless of clk, Result SHALL be 0, carry_out 0, overflow 0, zero 1, negative 0 and out_valid 0.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight result, so that out_valid is never asserted for it.
REQ-025 The first operation after reset is released SHALL be accepted on the first rising edge where reset=0 and in_valid=1.

Structure
REQ-026 A shared package SHALL hold the op encodings (OP_ADD=0, OP_SUB=1) and the default WIDTH.
REQ-027 The carry chain SHALL be built from 4-bit carry-lookahead groups, using one sub-module named cla4 (inputs a, b, cin; outputs sum, generate, propagate, cout), rippled between groups.
REQ-028 WIDTH SHALL be a multiple of 4.
REQ-029 The datapath SHALL NOT use a behavioural + or - operator.

Verification
REQ-030 Reset: assert reset asynchronously mid-cycle -> all outputs at their reset values immediately, with zero=1 and out_valid=0.
REQ-031 Add: A=5, B=7, op=0 -> one cycle later Result=12, carry_out=0, overflow=0, zero=0, negative=0, out_valid=1.
REQ-032 Subtract: A=3, B=5, op=1 -> Result=0xFFFFFFFE, negative=1, carry_out=0 (borrow), overflow=0.
REQ-033 Overflow: A=0x7FFFFFFF, B=1, op=0 -> Result=0x80000000, overflow=1; then A=0x80000000, B=1, op=1 -> Result=0x7FFFFFFF, overflow=1.
REQ-034 Wrap and zero: A=0xFFFFFFFF, B=1, op=0 -> Result=0, zero=1, carry_out=1; and A=B=0x12345678, op=1 -> Result=0, zero=1, carry_out=1.
REQ-035 Streaming: issue 100 random back-to-back operations with in_valid gaps -> each result matches the reference model exactly one cycle later, and out_valid tracks in_valid delayed by one cycle.

Source files
------------

// File: rtl/adder_subtractor_pkg.sv
// Shared definitions for the adder/subtractor datapath:
// op encodings, default width and carry-lookahead group size.
package adder_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int GROUP_WIDTH   = 4;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead group: local sum plus group
// generate/propagate terms and the group carry out.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       gen,
   output logic       prop,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   // Lookahead carries computed in parallel from g/p and cin
   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
      gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
      prop = &p;
      cout = gen | (prop & cin);
      sum  = p ^ c;
   end

endmodule

// File: rtl/adder_subtractor.sv
// Registered add/subtract unit with NZCV-style flags.
// One carry chain serves both ops: subtract inverts B and sets cin.
module adder_subtractor
   import adder_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   output logic [WIDTH-1:0] Result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int GROUPS = WIDTH / GROUP_WIDTH;

   logic              sub;
   logic [WIDTH-1:0]  b_eff;
   logic [WIDTH-1:0]  sum;
   logic [GROUPS:0]   carry;
   logic [GROUPS-1:0] grp_gen;
   logic [GROUPS-1:0] grp_prop;
   logic              msb_cin;
   logic              ovf_next;
   logic              unused_lookahead;

   assign sub      = (op == OP_SUB);
   assign b_eff    = B ^ {WIDTH{sub}};
   assign carry[0] = sub;

   // Group generate/propagate are exposed for a future second-level
   // lookahead; the chain below ripples group couts instead.
   assign unused_lookahead = ^{grp_gen, grp_prop};

   for (genvar i = 0; i < GROUPS; i++) begin : g_cla
      cla4 u_cla (
         .a    (A[i*GROUP_WIDTH +: GROUP_WIDTH]),
         .b    (b_eff[i*GROUP_WIDTH +: GROUP_WIDTH]),
         .cin  (carry[i]),
         .sum  (sum[i*GROUP_WIDTH +: GROUP_WIDTH]),
         .gen  (grp_gen[i]),
         .prop (grp_prop[i]),
         .cout (carry[i+1])
      );
   end

   // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c
   assign msb_cin  = sum[WIDTH-1] ^ A[WIDTH-1] ^ b_eff[WIDTH-1];
   assign ovf_next = msb_cin ^ carry[GROUPS];

   // Capture result and flags only for valid ops; hold otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         Result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            Result    <= sum;
            carry_out <= carry[GROUPS];
            overflow  <= ovf_next;
         end
      end
   end

   assign zero     = ~|Result;
   assign negative = Result[WIDTH-1];

endmodule

// File: tb/tb_adder_subtractor.sv
// Scoreboard bench for adder_subtractor: directed corner cases,
// async reset behaviour and a randomized stream with gaps.
module tb_adder_subtractor;

   localparam int W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct {
      logic [W-1:0] res;
      logic         c;
      logic         v;
      logic         z;
      logic         n;
   } exp_t;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         op;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         out_valid;
   logic [W-1:0] Result;
   logic         carry_out;
   logic         overflow;
   logic         zero;
   logic         negative;

   exp_t q[$];
   exp_t hold;
   exp_t rst_val;
   int   tests = 0;
   int   fails = 0;

   adder_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .op        (op),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .Result    (Result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model(logic o, logic [W-1:0] a,
                                  logic [W-1:0] b);
      exp_t e;
      longint sa, sb, sr;
      longint unsigned ua, ub;
      ua = 64'(a);
      ub = 64'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (o == 1'b0) begin
         e.res = a + b;
         e.c   = (ua + ub) >= 64'h1_0000_0000;
         sr    = sa + sb;
      end else begin
         e.res = a - b;
         e.c   = (ua >= ub);
         sr    = sa - sb;
      end
      e.v = (sr > SMAX) || (sr < SMIN);
      e.z = (e.res == '0);
      e.n = e.res[W-1];
      return e;
   endfunction

   task automatic chk(string name, logic [W-1:0] got,
                      logic [W-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, got, exp, $time);
      end
   endtask

   task automatic chk_all(string tag, exp_t e);
      chk({tag, ".result"},   Result,        e.res);
      chk({tag, ".carry"},    W'(carry_out), W'(e.c));
      chk({tag, ".overflow"}, W'(overflow),  W'(e.v));
      chk({tag, ".zero"},     W'(zero),      W'(e.z));
      chk({tag, ".negative"}, W'(negative),  W'(e.n));
   endtask

   task automatic chk_reset(string tag);
      chk_all(tag, rst_val);
      chk({tag, ".out_valid"}, W'(out_valid), W'(0));
   endtask

   // Expected response queued when an op is accepted at the edge
   always @(posedge clk) begin
      if (!reset && in_valid)
         q.push_back(model(op, A, B));
   end

   // Monitor: compares one cycle later, away from the edge
   always @(posedge clk) begin
      logic ev;
      exp_t e;
      ev = !reset && in_valid;
      #1;
      if (reset) begin
         chk_reset("reset_hold");
         q.delete();
         hold = rst_val;
      end else begin
         chk("out_valid_track", W'(out_valid), W'(ev));
         if (out_valid) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out: got out_valid 1 expected empty queue at %0t",
                        $time);
            end else begin
               e = q.pop_front();
               chk_all("result", e);
               hold = e;
            end
         end else begin
            chk_all("hold", hold);
         end
      end
   end

   task automatic issue(logic o, logic [W-1:0] a, logic [W-1:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      op       = o;
      A        = a;
      B        = b;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      op       = 1'bx;
      A        = 'x;
      B        = 'x;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      rst_val  = '{res: '0, c: 1'b0, v: 1'b0, z: 1'b1, n: 1'b0};
      hold     = rst_val;
      reset    = 1'b0;
      in_valid = 1'b0;
      op       = 1'b0;
      A        = '0;
      B        = '0;
      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      issue(1'b0, 32'd5,          32'd7);
      issue(1'b1, 32'd3,          32'd5);
      issue(1'b0, 32'h7FFF_FFFF,  32'd1);
      issue(1'b1, 32'h8000_0000,  32'd1);
      issue(1'b0, 32'hFFFF_FFFF,  32'd1);
      issue(1'b1, 32'h1234_5678,  32'h1234_5678);
      idle();
      idle();

      // Async reset asserted mid-cycle while a result is showing
      issue(1'b0, 32'hDEAD_0000, 32'h0000_BEEF);
      idle();
      @(posedge clk);
      #3 reset = 1'b1;
      #1 chk_reset("async_reset");

      // In-flight op discarded when reset lands before its edge
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b1;
      op       = 1'b0;
      A        = 32'd9;
      B        = 32'd9;
      #3 reset = 1'b1;
      @(posedge clk);
      #1 chk("discard.out_valid", W'(out_valid), W'(0));

      // First op after release accepted on the first free edge
      @(negedge clk);
      reset = 1'b0;
      A     = 32'd2;
      B     = 32'd3;
      idle();
      idle();

      for (int n = 0; n < 100;) begin
         @(negedge clk);
         if ($urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            op       = 1'($urandom);
            A        = pick();
            B        = pick();
            n++;
         end else begin
            in_valid = 1'b0;
            op       = 1'bx;
            A        = 'x;
            B        = 'x;
         end
      end
      idle();
      repeat (3) @(negedge clk);

      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
